// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input in clk cycles.
// A result is reported only for complete rising-to-rising periods. Loss of signal is flagged
// when no rising edge arrives within TIMEOUT cycles.
module pwm_capture #(
    parameter int unsigned  W       = 28,
    parameter logic [W-1:0] TIMEOUT = 28'd2_500_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pwm_in,
    output logic [W-1:0] period,
    output logic [W-1:0] duty,
    output logic         valid,
    output logic         lost
);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    state_e       state_q, state_d;
    logic         s1_q, s2_q, sd_q;
    logic         rise, fall;
    logic [W-1:0] cnt_q;
    logic [W-1:0] hlat_q;
    logic         timeout_hit;
    logic         load_hlat;
    logic         load_result;

    assign rise = s2_q & ~sd_q;
    assign fall = ~s2_q & sd_q;

    // Timeout applies only while measuring; a rise in the same cycle restarts instead.
    assign timeout_hit = (state_q != StIdle) && (cnt_q == TIMEOUT) && !rise;

    // Two-flop synchroniser plus a delay stage for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            sd_q <= 1'b0;
        end else begin
            s1_q <= pwm_in;
            s2_q <= s1_q;
            sd_q <= s2_q;
        end
    end

    // Cycle counter: restarts at 1 on every rise, saturates at TIMEOUT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (rise) begin
            cnt_q <= W'(1);
        end else if (cnt_q < TIMEOUT) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rise) state_d = StHigh;
            end
            StHigh: begin
                if (timeout_hit) state_d = StIdle;
                else if (fall)   state_d = StLow;
            end
            StLow: begin
                if (rise)             state_d = StHigh;
                else if (timeout_hit) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM output decode: datapath load enables.
    always_comb begin
        load_hlat   = (state_q == StHigh) && fall && !timeout_hit;
        load_result = (state_q == StLow) && rise;
    end

    // Result registers; period/duty hold across a timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hlat_q <= '0;
            period <= '0;
            duty   <= '0;
            valid  <= 1'b0;
            lost   <= 1'b0;
        end else begin
            valid <= load_result;
            if (load_hlat) begin
                hlat_q <= cnt_q;
            end
            if (load_result) begin
                period <= cnt_q;
                duty   <= hlat_q;
                lost   <= 1'b0;
            end else if (timeout_hit) begin
                lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture (W=28, TIMEOUT=5000).
module tb_pwm_capture;

    localparam int unsigned W  = 28;
    localparam int unsigned TO = 5000;

    logic         clk;
    logic         reset;
    logic         pwm_in;
    logic [W-1:0] period;
    logic [W-1:0] duty;
    logic         valid;
    logic         lost;

    int unsigned checks;
    int unsigned failures;

    // Strobe log filled by the monitor.
    int unsigned  cyc;
    int unsigned  strobe_cyc[$];
    logic [W-1:0] strobe_per[$];
    logic [W-1:0] strobe_duty[$];
    logic         lost_prev;
    int unsigned  lost_set_cyc;
    int unsigned  lost_clr_cyc;

    pwm_capture #(
        .W       (W),
        .TIMEOUT (28'd5000)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pwm_in (pwm_in),
        .period (period),
        .duty   (duty),
        .valid  (valid),
        .lost   (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample outputs on the falling edge, away from the active edge.
    initial begin
        cyc          = 0;
        lost_prev    = 1'b0;
        lost_set_cyc = 0;
        lost_clr_cyc = 0;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (valid) begin
            strobe_cyc.push_back(cyc);
            strobe_per.push_back(period);
            strobe_duty.push_back(duty);
        end
        if (lost && !lost_prev) lost_set_cyc = cyc;
        if (!lost && lost_prev) lost_clr_cyc = cyc;
        lost_prev = lost;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_period(input int p, input int h);
        pwm_in = 1'b1;
        wait_cyc(h);
        pwm_in = 1'b0;
        wait_cyc(p - h);
    endtask

    int unsigned base;
    int unsigned n;
    int unsigned exp_duty;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        pwm_in   = 1'b0;
        wait_cyc(3);
        check("rst_period", 32'(period), 0);
        check("rst_duty", 32'(duty), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_lost", 32'(lost), 0);
        reset = 1'b0;
        wait_cyc(100);
        check("idle_no_strobe", strobe_cyc.size(), 0);
        check("idle_lost", 32'(lost), 0);

        // Good stream, duty step to 850 and back, then input stuck high.
        base = strobe_cyc.size();
        repeat (5) drive_period(1000, 150);
        repeat (3) drive_period(1000, 850);
        repeat (3) drive_period(1000, 150);
        pwm_in = 1'b1;
        wait_cyc(TO + 100);
        n = strobe_cyc.size() - base;
        check("stream_count", n, 11);
        if (n == 11) begin
            for (int i = 0; i < 11; i++) begin
                exp_duty = (i >= 5 && i < 8) ? 850 : 150;
                check("stream_period", 32'(strobe_per[base + i]), 1000);
                check("stream_duty", 32'(strobe_duty[base + i]), exp_duty);
                if (i > 0) begin
                    check("stream_spacing",
                          strobe_cyc[base + i] - strobe_cyc[base + i - 1], 1000);
                end
            end
            check("lost_delay", lost_set_cyc - strobe_cyc[base + 10], TO);
        end
        check("lost_set", 32'(lost), 1);
        check("lost_hold_period", 32'(period), 1000);
        check("lost_hold_duty", 32'(duty), 150);
        check("lost_valid", 32'(valid), 0);

        // Recovery with a 1000/300 stream.
        base   = strobe_cyc.size();
        pwm_in = 1'b0;
        wait_cyc(500);
        check("recover_lost_still", 32'(lost), 1);
        repeat (2) drive_period(1000, 300);
        pwm_in = 1'b1;
        wait_cyc(20);
        n = strobe_cyc.size() - base;
        check("recover_count", n, 2);
        if (n == 2) begin
            check("recover_period", 32'(strobe_per[base]), 1000);
            check("recover_duty", 32'(strobe_duty[base]), 300);
            check("recover_lost_clr", lost_clr_cyc, strobe_cyc[base]);
            check("recover_spacing", strobe_cyc[base + 1] - strobe_cyc[base], 1000);
            check("recover_duty2", 32'(strobe_duty[base + 1]), 300);
        end
        check("recover_lost", 32'(lost), 0);

        // Reset asserted halfway through a high phase.
        pwm_in = 1'b0;
        wait_cyc(600);
        pwm_in = 1'b1;
        wait_cyc(75);
        base  = strobe_cyc.size();
        reset = 1'b1;
        #1;
        check("async_period", 32'(period), 0);
        check("async_duty", 32'(duty), 0);
        check("async_valid", 32'(valid), 0);
        check("async_lost", 32'(lost), 0);
        wait_cyc(75);
        pwm_in = 1'b0;
        wait_cyc(150);
        reset = 1'b0;
        wait_cyc(700);
        repeat (2) drive_period(1000, 150);
        pwm_in = 1'b1;
        wait_cyc(20);
        n = strobe_cyc.size() - base;
        check("post_rst_count", n, 2);
        if (n == 2) begin
            check("post_rst_period", 32'(strobe_per[base]), 1000);
            check("post_rst_duty", 32'(strobe_duty[base]), 150);
            check("post_rst_spacing", strobe_cyc[base + 1] - strobe_cyc[base], 1000);
            check("post_rst_period2", 32'(strobe_per[base + 1]), 1000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive side of the PWM path: measures the period and high time of an external PWM input (RC receiver channel, or loop-back of the generator output) in clk cycles.
- Widths match the generator's 28-bit period/duty registers, so a captured period/duty pair can be written straight back into a generator, or exported to the Nios II through PIO ports.
- Flags loss of signal when no rising edge arrives within a programmable timeout.

Parameters:
- W, 28, counter and result width in bits.
- TIMEOUT, 28'd2_500_000, cycles without a rising edge before signal loss is declared (50 ms at 50 MHz). Must satisfy 2 <= TIMEOUT <= 2^W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- pwm_in  in  1  PWM input, asynchronous to clk
- period  out  W  last complete measured period, in cycles, rising edge to rising edge
- duty  out  W  high time of that same period, in cycles
- valid  out  1  one-cycle strobe: period and duty updated this cycle
- lost  out  1  level: no rising edge within TIMEOUT cycles

Behaviour:
- Reset (asynchronous, active-high): all flops clear, state=IDLE.
  - period=0, duty=0, valid=0, lost=0.
  - Both synchroniser stages and the delay register are cleared to 0.
  - A pwm_in that is high at reset release is therefore seen as a rising edge after synchronisation.
- Synchroniser and edge detect:
  - s1 <= pwm_in; s2 <= s1; sd <= s2.
  - rise = s2 & ~sd; fall = ~s2 & sd.
  - Input-to-detect latency is 3 clk edges.
- Counter cnt (W bits):
  - On rise: cnt <= 1.
  - Otherwise, if cnt < TIMEOUT: cnt <= cnt+1.
  - Otherwise cnt holds (saturates at TIMEOUT, no wrap).
- States:
  - IDLE: waiting for the first rising edge. rise -> HIGH. No outputs are produced.
  - HIGH: on fall, hlat <= cnt and go to LOW.
  - LOW: on rise, period <= cnt, duty <= hlat, valid <= 1, lost <= 0, and go to HIGH.
- Result: a stable input with period P and high time H gives period=P, duty=H exactly.
- Timing of valid: valid is registered and asserts on the same clk edge that loads period/duty. It is 0 on every other cycle.
- Timeout: in HIGH or LOW, when cnt == TIMEOUT and no rise is present:
  - lost <= 1 and state <= IDLE.
  - period and duty hold their last values.
  - This covers both a stuck-low and a stuck-high input.
- Recovery: from IDLE, the first rise enters HIGH. The next full cycle yields valid and clears lost. The partial first cycle is never reported.
- Precedence: rise and a timeout in the same cycle -> rise wins (counter restarts, no lost).
- Degenerate pulse: a fall with no preceding rise can only occur in IDLE or LOW and is ignored.
- Minimum resolvable pulse: 1 cycle high or low after synchronisation. Shorter glitches may be missed; no filtering is provided.
- Reset mid-measurement: everything is discarded, return to IDLE, outputs go to 0.

Test Plan:
- Reset with pwm_in=0 -> period=0, duty=0, valid=0, lost=0. Hold for 100 cycles -> no valid.
- pwm_in with P=1000, H=150 for 5 periods:
  - valid strobes once per period, starting at the end of the first complete period after the first edge.
  - period=1000 and duty=150 on every strobe.
  - Strobe spacing is exactly 1000 cycles.
- Step duty from H=150 to H=850 mid-stream (P=1000):
  - The strobe covering the changed cycle reports duty=850.
  - No strobe reports an intermediate value.
- TIMEOUT=5000, pwm_in stuck high after a good 1000/150 stream:
  - lost=1 exactly TIMEOUT cycles after the last counter restart.
  - period=1000 and duty=150 retained; no valid.
- Resume 1000/300 after loss:
  - First rise gives no valid.
  - Second rise gives valid, period=1000, duty=300, and lost deasserts on that same edge.
- Assert reset halfway through a HIGH phase:
  - Outputs go to 0 immediately (asynchronous).
  - After release, the first valid comes only after a full new period; values are correct.
